// File: rtl/ocm_swio_ctrl_pkg.sv
// rtl/ocm_swio_ctrl_pkg.sv - shared constants, lock FSM states and ID filter for the switched-I/O block
package ocm_swio_ctrl_pkg;

    localparam logic [7:0] SWIO_ID_MSX008 = 8'h08;
    localparam logic [7:0] SWIO_ID_OCM212 = 8'hD4;
    localparam logic [7:0] SWIO_ID_NONE   = 8'hFF;

    localparam int SWIO_ST_FULL  = 7;
    localparam int SWIO_ST_EMPTY = 6;
    localparam int SWIO_ST_OVF   = 5;

    localparam logic [3:0] SWIO_PORT_ID   = 4'h0;
    localparam logic [3:0] SWIO_PORT_CMD  = 4'h1;
    localparam logic [3:0] SWIO_PORT_JIS2 = 4'hE;
    localparam logic [3:0] SWIO_PORT_MODE = 4'hF;

    localparam logic [7:0] SWIO_F4_ADDR   = 8'hF4;

    typedef enum logic [0:0] {
        LOCK_BOOT   = 1'b0,
        LOCK_LOCKED = 1'b1
    } lock_state_e;

    // Only the two known device IDs can be selected; anything else deselects.
    function automatic logic [7:0] swio_id_filter(input logic [7:0] v);
        return ((v == SWIO_ID_MSX008) || (v == SWIO_ID_OCM212)) ? v : SWIO_ID_NONE;
    endfunction

endpackage

// File: rtl/ocm_cmd_fifo.sv
// rtl/ocm_cmd_fifo.sv - synchronous smart-command FIFO with push, pop, full, empty and level
module ocm_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_data,
    output logic       o_full,
    output logic       o_empty,
    output logic [3:0] o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [3:0]    r_level;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_level == 4'(DEPTH));
    assign o_empty   = (r_level == 4'd0);
    assign o_level   = r_level;
    assign o_data    = r_mem[r_rd_ptr];
    // A pop frees the head slot on the same edge, so a full FIFO can still accept.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 4'd1;
                2'b01:   r_level <= r_level - 4'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/ocm_swio_ctrl.sv
// rtl/ocm_swio_ctrl.sv - OCM switched-I/O controller, ports $40-$4F (plus $F4 with OCM_SWIO_PORTF4_EN)
module ocm_swio_ctrl
    import ocm_swio_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    input  logic       wr,
    input  logic       rd,
    input  logic       iorq,
    input  logic       m1,
    input  logic       req,
    input  logic       boot_active,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       jis2_ena,
    output logic       portf4_mode,
    output logic       warm_logo,
    output logic       cmd_valid,
    output logic [7:0] cmd_data,
    input  logic       cmd_ready
);

    lock_state_e r_state;
    logic [7:0]  r_id_reg;
    logic        r_overflow;

    logic        w_hit;
    logic [3:0]  w_port;
    logic        w_ocm_sel;
    logic        w_wr_en;
    logic        w_rd_en;
    logic        w_push;
    logic        w_pop;
    logic        w_drop;
    logic        w_stat_rd;
    logic        w_full;
    logic        w_empty;
    logic [3:0]  w_level;

    assign w_hit     = req & iorq & ~m1 & (addr[7:4] == 4'h4);
    assign w_port    = addr[3:0];
    assign w_ocm_sel = (r_id_reg == SWIO_ID_OCM212);
    assign w_wr_en   = w_hit & wr;
    assign w_rd_en   = w_hit & rd;
    assign w_push    = w_wr_en & w_ocm_sel & (w_port == SWIO_PORT_CMD);
    assign w_stat_rd = w_rd_en & w_ocm_sel & (w_port == SWIO_PORT_CMD);
    assign w_pop     = cmd_valid & cmd_ready;
    assign w_drop    = w_push & w_full & ~w_pop;
    assign cmd_valid = ~w_empty;

    ocm_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (data_in),
        .i_pop   (w_pop),
        .o_data  (cmd_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= LOCK_BOOT;
            r_id_reg    <= SWIO_ID_NONE;
            r_overflow  <= 1'b0;
            jis2_ena    <= 1'b0;
            portf4_mode <= 1'b0;
            warm_logo   <= 1'b0;
        end else begin
            if (!boot_active) r_state <= LOCK_LOCKED;
            if (w_wr_en && (w_port == SWIO_PORT_ID)) r_id_reg <= swio_id_filter(data_in);
            // IPL-only registers are frozen once the boot window has closed.
            if (w_wr_en && w_ocm_sel && (r_state == LOCK_BOOT)) begin
                if (w_port == SWIO_PORT_JIS2) jis2_ena <= ~data_in[7];
                if (w_port == SWIO_PORT_MODE) begin
                    portf4_mode <= ~data_in[7];
                    warm_logo   <= ~data_in[7];
                end
            end
            if (w_drop)         r_overflow <= 1'b1;
            else if (w_stat_rd) r_overflow <= 1'b0;
        end
    end

`ifdef OCM_SWIO_PORTF4_EN
    logic [7:0] r_f4_reg;
    logic       w_f4_hit;

    assign w_f4_hit = req & iorq & ~m1 & (addr == SWIO_F4_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)              r_f4_reg <= 8'h00;
        else if (w_f4_hit & wr) r_f4_reg <= data_in;
    end
`endif

    always_comb begin
        data_out = 8'hFF;
        data_oe  = 1'b0;
        if (w_rd_en && (w_port == SWIO_PORT_ID) && (r_id_reg != SWIO_ID_NONE)) begin
            data_out = ~r_id_reg;
            data_oe  = 1'b1;
        end else if (w_stat_rd) begin
            data_out                = {4'b0000, w_level};
            data_out[SWIO_ST_FULL]  = w_full;
            data_out[SWIO_ST_EMPTY] = w_empty;
            data_out[SWIO_ST_OVF]   = r_overflow;
            data_oe                 = 1'b1;
        end
`ifdef OCM_SWIO_PORTF4_EN
        if (w_f4_hit && rd && portf4_mode) begin
            data_out = r_f4_reg;
            data_oe  = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_ocm_swio_ctrl.sv
// tb/tb_ocm_swio_ctrl.sv - directed self-checking bench for ocm_swio_ctrl
module tb_ocm_swio_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] addr;
    logic [7:0] data_in;
    logic       wr, rd, iorq, m1, req;
    logic       boot_active;
    logic [7:0] data_out;
    logic       data_oe;
    logic       jis2_ena, portf4_mode, warm_logo;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;

    int n_cmp = 0;
    int n_fail = 0;

    ocm_swio_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .data_in     (data_in),
        .wr          (wr),
        .rd          (rd),
        .iorq        (iorq),
        .m1          (m1),
        .req         (req),
        .boot_active (boot_active),
        .data_out    (data_out),
        .data_oe     (data_oe),
        .jis2_ena    (jis2_ena),
        .portf4_mode (portf4_mode),
        .warm_logo   (warm_logo),
        .cmd_valid   (cmd_valid),
        .cmd_data    (cmd_data),
        .cmd_ready   (cmd_ready)
    );

    always #5 clk = ~clk;

    task automatic bus_idle();
        req = 0; iorq = 0; wr = 0; rd = 0; m1 = 0; addr = 8'h00; data_in = 8'h00;
    endtask

    task automatic io_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; data_in = d; req = 1; iorq = 1; wr = 1;
        @(posedge clk);
        #1 bus_idle();
    endtask

    task automatic io_rd(input logic [7:0] a, output logic [7:0] d, output logic oe);
        @(negedge clk);
        addr = a; req = 1; iorq = 1; rd = 1;
        #1 d = data_out; oe = data_oe;
        @(posedge clk);
        #1 bus_idle();
    endtask

    task automatic test_reset();
        logic [7:0] d; logic oe;
        n_cmp++; if (data_out !== 8'hFF) begin n_fail++; $display("FAIL reset_data_out got %h want ff", data_out); end
        n_cmp++; if (data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe got %b want 0", data_oe); end
        n_cmp++; if ({jis2_ena, portf4_mode, warm_logo} !== 3'b000) begin n_fail++; $display("FAIL reset_cfg got %b want 000", {jis2_ena, portf4_mode, warm_logo}); end
        n_cmp++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid got %b want 0", cmd_valid); end
        io_rd(8'h40, d, oe);
        n_cmp++; if (oe !== 1'b0) begin n_fail++; $display("FAIL reset_id_read oe got %b want 0", oe); end
    endtask

    task automatic test_id();
        logic [7:0] d; logic oe;
        io_wr(8'h41, 8'h99);
        n_cmp++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL id_none_push cmd_valid got %b want 0", cmd_valid); end
        io_wr(8'h40, 8'hD4);
        io_rd(8'h40, d, oe);
        n_cmp++; if ({oe, d} !== {1'b1, 8'h2B}) begin n_fail++; $display("FAIL id_d4_read got %b/%h want 1/2b", oe, d); end
        io_wr(8'h40, 8'h08);
        io_rd(8'h40, d, oe);
        n_cmp++; if ({oe, d} !== {1'b1, 8'hF7}) begin n_fail++; $display("FAIL id_08_read got %b/%h want 1/f7", oe, d); end
        io_rd(8'h41, d, oe);
        n_cmp++; if (oe !== 1'b0) begin n_fail++; $display("FAIL id_08_stat oe got %b want 0", oe); end
        io_wr(8'h40, 8'h55);
        io_rd(8'h40, d, oe);
        n_cmp++; if (oe !== 1'b0) begin n_fail++; $display("FAIL id_55_read oe got %b want 0", oe); end
        io_wr(8'h40, 8'hD4);
    endtask

    task automatic test_portf4();
        logic [7:0] d; logic oe;
        io_wr(8'hF4, 8'h5A);
        io_rd(8'hF4, d, oe);
        n_cmp++; if (oe !== 1'b0) begin n_fail++; $display("FAIL f4_mode0 oe got %b want 0", oe); end
        io_wr(8'h4F, 8'h00);
        n_cmp++; if ({portf4_mode, warm_logo} !== 2'b11) begin n_fail++; $display("FAIL mode_set got %b want 11", {portf4_mode, warm_logo}); end
        io_rd(8'hF4, d, oe);
`ifdef OCM_SWIO_PORTF4_EN
        n_cmp++; if ({oe, d} !== {1'b1, 8'h5A}) begin n_fail++; $display("FAIL f4_mode1 got %b/%h want 1/5a", oe, d); end
`else
        n_cmp++; if (oe !== 1'b0) begin n_fail++; $display("FAIL f4_undecoded oe got %b want 0", oe); end
`endif
        io_wr(8'h4F, 8'h80);
        n_cmp++; if ({portf4_mode, warm_logo} !== 2'b00) begin n_fail++; $display("FAIL mode_clear got %b want 00", {portf4_mode, warm_logo}); end
    endtask

    task automatic test_lock();
        logic [7:0] d; logic oe;
        io_wr(8'h4E, 8'h00);
        n_cmp++; if (jis2_ena !== 1'b1) begin n_fail++; $display("FAIL jis2_boot got %b want 1", jis2_ena); end
        @(negedge clk); boot_active = 0;
        @(negedge clk);
        io_wr(8'h4E, 8'h80);
        n_cmp++; if (jis2_ena !== 1'b1) begin n_fail++; $display("FAIL jis2_locked got %b want 1", jis2_ena); end
        io_wr(8'h4F, 8'h00);
        n_cmp++; if (portf4_mode !== 1'b0) begin n_fail++; $display("FAIL mode_locked got %b want 0", portf4_mode); end
        io_rd(8'h4E, d, oe);
        n_cmp++; if (oe !== 1'b0) begin n_fail++; $display("FAIL read_4e oe got %b want 0", oe); end
    endtask

    task automatic test_overflow();
        logic [7:0] d; logic oe;
        cmd_ready = 0;
        for (int i = 0; i < 5; i++) io_wr(8'h41, 8'h11 + 8'(i));
        io_rd(8'h41, d, oe);
        n_cmp++; if ({oe, d} !== {1'b1, 8'hA4}) begin n_fail++; $display("FAIL stat_ovf got %b/%h want 1/a4", oe, d); end
        io_rd(8'h41, d, oe);
        n_cmp++; if ({oe, d} !== {1'b1, 8'h84}) begin n_fail++; $display("FAIL stat_ovf_clr got %b/%h want 1/84", oe, d); end
        n_cmp++; if ({cmd_valid, cmd_data} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL head_11 got %b/%h want 1/11", cmd_valid, cmd_data); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d; logic oe;
        logic [7:0] exp_q [4];
        exp_q = '{8'h12, 8'h13, 8'h14, 8'h16};
        @(negedge clk);
        addr = 8'h41; data_in = 8'h16; req = 1; iorq = 1; wr = 1; cmd_ready = 1;
        @(posedge clk);
        #1 bus_idle(); cmd_ready = 0;
        io_rd(8'h41, d, oe);
        n_cmp++; if ({oe, d} !== {1'b1, 8'h84}) begin n_fail++; $display("FAIL full_pushpop_stat got %b/%h want 1/84", oe, d); end
        n_cmp++; if (cmd_data !== 8'h12) begin n_fail++; $display("FAIL full_pushpop_head got %h want 12", cmd_data); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); cmd_ready = 1;
            #1;
            n_cmp++; if ({cmd_valid, cmd_data} !== {1'b1, exp_q[i]}) begin n_fail++; $display("FAIL drain_%0d got %b/%h want 1/%h", i, cmd_valid, cmd_data, exp_q[i]); end
            @(posedge clk);
        end
        @(negedge clk); cmd_ready = 0;
        n_cmp++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL drained_valid got %b want 0", cmd_valid); end
        io_rd(8'h41, d, oe);
        n_cmp++; if ({oe, d} !== {1'b1, 8'h40}) begin n_fail++; $display("FAIL stat_empty got %b/%h want 1/40", oe, d); end
    endtask

    task automatic test_latency_reset();
        logic [7:0] d; logic oe;
        @(negedge clk);
        addr = 8'h41; data_in = 8'h7E; req = 1; iorq = 1; wr = 1;
        #1;
        n_cmp++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL push_same_cycle valid got %b want 0", cmd_valid); end
        @(posedge clk);
        #1 bus_idle();
        n_cmp++; if ({cmd_valid, cmd_data} !== {1'b1, 8'h7E}) begin n_fail++; $display("FAIL push_next_cycle got %b/%h want 1/7e", cmd_valid, cmd_data); end
        @(negedge clk); reset = 1;
        #1;
        n_cmp++; if ({cmd_valid, jis2_ena} !== 2'b00) begin n_fail++; $display("FAIL midreset got %b want 00", {cmd_valid, jis2_ena}); end
        @(negedge clk); reset = 0;
        io_rd(8'h40, d, oe);
        n_cmp++; if (oe !== 1'b0) begin n_fail++; $display("FAIL midreset_id oe got %b want 0", oe); end
        io_wr(8'h40, 8'hD4);
        io_wr(8'h4E, 8'h00);
        n_cmp++; if (jis2_ena !== 1'b0) begin n_fail++; $display("FAIL relock_jis2 got %b want 0", jis2_ena); end
    endtask

    initial begin
        bus_idle();
        reset = 1; boot_active = 1; cmd_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 0;
        #1;
        test_reset();
        test_id();
        test_portf4();
        test_lock();
        test_overflow();
        test_back_to_back();
        test_latency_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
